// File: rtl/conv_window_seq.sv
// conv_window_seq
//
// Address sequencer for the 5x5 convolution MAC engine. Walks every K_W x K_W
// window of a MAP_W x MAP_W feature map. For each tap it issues one
// (map address, kernel address) pair per cycle to the synchronous map RAM and
// kernel ROM that feed the MAC operands. It also owns the MAC hold/clear input
// and gives the layer controller a start/busy/done handshake.
//
// Ports
//   clk_in    in   clock
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, only looked at in IDLE
//   abort     in   synchronous cancel; wins over start
//   busy      out  high in every state other than IDLE
//   done      out  one-cycle pulse when a run completes normally
//   mac_hold  out  1 = MAC held/cleared, 0 = MAC accumulating
//   rd_en     out  address pair valid this cycle
//   map_addr  out  map RAM read address, (r+i)*MAP_W + (c+j)
//   k_addr    out  kernel ROM read address, i*K_W + j
//   win_last  out  marks the last tap of each window
//   out_idx   out  output pixel index r*OUT_W + c of the current window
//
// State table
//   state | meaning
//   IDLE  | MAC held; waiting for start
//   WARM  | hold released; waits WARM_CYC cycles for the MAC hold-delay pipe
//   RUN   | one address pair per cycle, no gaps, for every tap of every window
//   DRAIN | no reads; waits DRAIN_CYC cycles for the last products to land
//   DONE  | single cycle: done pulse, MAC held again
//
// Every output is a flop. Each one is loaded from a value decoded from the
// next state, so outputs change on the same edge as the state register.

module conv_window_seq #(
    parameter int MAP_W     = 22,
    parameter int K_W       = 5,
    parameter int OUT_W     = 18,
    parameter int MA_W      = 9,
    parameter int KA_W      = 5,
    parameter int WARM_CYC  = 3,
    parameter int DRAIN_CYC = 8
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            mac_hold,
    output logic            rd_en,
    output logic [MA_W-1:0] map_addr,
    output logic [KA_W-1:0] k_addr,
    output logic            win_last,
    output logic [8:0]      out_idx
);

    localparam int IJ_W  = (K_W > 1) ? $clog2(K_W) : 1;
    localparam int RC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int TMR_W = 8;

    localparam logic [IJ_W-1:0]  IJ_MAX   = IJ_W'(K_W - 1);
    localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(OUT_W - 1);
    localparam logic [TMR_W-1:0] WARM_LD  = TMR_W'(WARM_CYC - 1);
    localparam logic [TMR_W-1:0] DRAIN_LD = TMR_W'(DRAIN_CYC - 1);
    localparam logic [MA_W-1:0]  ROW_STEP = MA_W'(MAP_W);
    // The window base moves from (r, OUT_W-1) to (r+1, 0). The address step is
    // MAP_W - (OUT_W-1), which equals K_W.
    localparam logic [MA_W-1:0]  WIN_ROW_STEP = MA_W'(MAP_W - OUT_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WARM  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [IJ_W-1:0]  i_q, i_d, j_q, j_d;
    logic [RC_W-1:0]  r_q, r_d, c_q, c_d;
    logic [MA_W-1:0]  win_base_q, win_base_d;   // map address of tap (0,0)
    logic [MA_W-1:0]  row_base_q, row_base_d;   // map address of tap (i,0)
    logic [MA_W-1:0]  map_addr_q, map_addr_d;
    logic [KA_W-1:0]  k_addr_q, k_addr_d;
    logic [8:0]       out_idx_q, out_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mac_hold_q, mac_hold_d;
    logic             rd_en_q, rd_en_d;
    logic             win_last_q, win_last_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            win_base_q <= '0;
            row_base_q <= '0;
            map_addr_q <= '0;
            k_addr_q   <= '0;
            out_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mac_hold_q <= 1'b1;
            rd_en_q    <= 1'b0;
            win_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            i_q        <= i_d;
            j_q        <= j_d;
            r_q        <= r_d;
            c_q        <= c_d;
            win_base_q <= win_base_d;
            row_base_q <= row_base_d;
            map_addr_q <= map_addr_d;
            k_addr_q   <= k_addr_d;
            out_idx_q  <= out_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mac_hold_q <= mac_hold_d;
            rd_en_q    <= rd_en_d;
            win_last_q <= win_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        i_d        = i_q;
        j_d        = j_q;
        r_d        = r_q;
        c_d        = c_q;
        win_base_d = win_base_q;
        row_base_d = row_base_q;
        map_addr_d = map_addr_q;
        k_addr_d   = k_addr_q;
        out_idx_d  = out_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_WARM;
                    tmr_d   = WARM_LD;
                end
            end

            ST_WARM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            ST_RUN: begin
                // The counters describe the tap being presented now. This
                // block works out the tap for the next cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (j_q != IJ_MAX) begin
                    j_d        = j_q + IJ_W'(1);
                    map_addr_d = map_addr_q + MA_W'(1);
                    k_addr_d   = k_addr_q + KA_W'(1);
                end else if (i_q != IJ_MAX) begin
                    j_d        = '0;
                    i_d        = i_q + IJ_W'(1);
                    row_base_d = row_base_q + ROW_STEP;
                    map_addr_d = row_base_q + ROW_STEP;
                    k_addr_d   = k_addr_q + KA_W'(1);
                end else if (c_q != RC_MAX) begin
                    j_d        = '0;
                    i_d        = '0;
                    c_d        = c_q + RC_W'(1);
                    win_base_d = win_base_q + MA_W'(1);
                    row_base_d = win_base_q + MA_W'(1);
                    map_addr_d = win_base_q + MA_W'(1);
                    k_addr_d   = '0;
                    out_idx_d  = out_idx_q + 9'd1;
                end else if (r_q != RC_MAX) begin
                    j_d        = '0;
                    i_d        = '0;
                    c_d        = '0;
                    r_d        = r_q + RC_W'(1);
                    win_base_d = win_base_q + WIN_ROW_STEP;
                    row_base_d = win_base_q + WIN_ROW_STEP;
                    map_addr_d = win_base_q + WIN_ROW_STEP;
                    k_addr_d   = '0;
                    out_idx_d  = out_idx_q + 9'd1;
                end else begin
                    state_d = ST_DRAIN;
                    tmr_d   = DRAIN_LD;
                end
            end

            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outside RUN the walk counters rest at zero. When WARM hands over to
        // RUN, the first pair (map 0, kernel 0, pixel 0) is therefore already
        // in place. An abort or a completed walk leaves nothing behind.
        if (state_d != ST_RUN) begin
            i_d        = '0;
            j_d        = '0;
            r_d        = '0;
            c_d        = '0;
            win_base_d = '0;
            row_base_d = '0;
            map_addr_d = '0;
            k_addr_d   = '0;
            out_idx_d  = '0;
        end
        if (state_d == ST_IDLE || state_d == ST_DONE) begin
            tmr_d = '0;
        end

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        mac_hold_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        rd_en_d    = (state_d == ST_RUN);
        win_last_d = (state_d == ST_RUN) && (i_d == IJ_MAX) && (j_d == IJ_MAX);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mac_hold = mac_hold_q;
    assign rd_en    = rd_en_q;
    assign map_addr = map_addr_q;
    assign k_addr   = k_addr_q;
    assign win_last = win_last_q;
    assign out_idx  = out_idx_q;

endmodule

// File: tb/tb_conv_window_seq.sv
// Testbench for conv_window_seq. The stimulus process pushes the expected
// address pairs and done pulses, each tagged with its expected cycle. The
// monitor pops them at every falling edge that shows rd_en or done.
`timescale 1ns/1ps

module tb_conv_window_seq;

    localparam int TAPS = 8100;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy, done, mac_hold, rd_en, win_last;
    logic [8:0] map_addr;
    logic [4:0] k_addr;
    logic [8:0] out_idx;

    conv_window_seq dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .mac_hold (mac_hold),
        .rd_en    (rd_en),
        .map_addr (map_addr),
        .k_addr   (k_addr),
        .win_last (win_last),
        .out_idx  (out_idx)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int map;
        int kad;
        int wl;
        int oidx;
    } tap_t;

    tap_t tap_q[$];
    int   done_q[$];

    int cyc_cnt   = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    int n_rd      = 0;
    int n_done    = 0;
    int exp_rd    = 0;
    int exp_done  = 0;

    bit cap_en = 1'b0;
    int cap_n  = 0;
    int cap_map[TAPS];
    int cap_kad[TAPS];
    int cap_oidx[TAPS];
    int cap_wl[TAPS];

    always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle count %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic wait_neg(input int t);
        while (cyc_cnt < t) @(negedge clk_in);
    endtask

    // Start sampled at edge s: taps appear from edge s+3 on, done at edge s+8111.
    task automatic push_run(input int s, input int ntaps, input bit with_done);
        tap_t e;
        for (int k = 0; k < ntaps; k++) begin
            int r, c, i, j;
            r = k / (18 * 25);
            c = (k / 25) % 18;
            i = (k % 25) / 5;
            j = k % 5;
            e.cyc  = s + 3 + k;
            e.map  = (r + i) * 22 + (c + j);
            e.kad  = i * 5 + j;
            e.wl   = (k % 25 == 24) ? 1 : 0;
            e.oidx = r * 18 + c;
            tap_q.push_back(e);
        end
        exp_rd += ntaps;
        if (with_done) begin
            done_q.push_back(s + 8111);
            exp_done++;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk_in) begin
        tap_t e;
        if (rst_n) begin
            if (rd_en || done)
                chk("rd_en_done_exclusive", int'(rd_en & done), 0);
            if (rd_en) begin
                n_rd++;
                chk("mac_hold_during_run", int'(mac_hold), 0);
                if (tap_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rd_en: got rd_en=1 map_addr=%0d, expected no read (cycle count %0d)", map_addr, cyc_cnt);
                end else begin
                    e = tap_q.pop_front();
                    chk("tap_cycle", cyc_cnt, e.cyc);
                    chk("map_addr", int'(map_addr), e.map);
                    chk("k_addr", int'(k_addr), e.kad);
                    chk("win_last", int'(win_last), e.wl);
                    chk("out_idx", int'(out_idx), e.oidx);
                end
                if (cap_en && cap_n < TAPS) begin
                    cap_map[cap_n]  = int'(map_addr);
                    cap_kad[cap_n]  = int'(k_addr);
                    cap_oidx[cap_n] = int'(out_idx);
                    cap_wl[cap_n]   = int'(win_last);
                    cap_n++;
                end
            end
            if (done) begin
                n_done++;
                chk("done_mac_hold", int'(mac_hold), 1);
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected none (cycle count %0d)", cyc_cnt);
                end else begin
                    chk("done_cycle", cyc_cnt, done_q.pop_front());
                end
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sA, sB, sC, sC2, sD;
        int spot_k[8]    = '{0, 4, 5, 24, 25, 450, 8075, 8099};
        int spot_map[8]  = '{0, 4, 22, 92, 1, 22, 391, 483};
        int spot_kad[8]  = '{0, 4, 5, 24, 0, 0, 0, 24};
        int spot_oidx[8] = '{0, 0, 0, 0, 1, 18, 323, 323};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mac_hold", int'(mac_hold), 1);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_map_addr", int'(map_addr), 0);
        chk("rst_k_addr", int'(k_addr), 0);
        chk("rst_win_last", int'(win_last), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("idle_busy", int'(busy), 0);

        // Run A: full run, with a stray start pulse in the middle of RUN
        start = 1'b1;
        sA = cyc_cnt + 1;
        push_run(sA, TAPS, 1'b1);
        cap_en = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        chk("cyc1_busy", int'(busy), 1);
        chk("cyc1_mac_hold", int'(mac_hold), 0);
        chk("cyc1_rd_en", int'(rd_en), 0);
        wait_neg(sA + 503);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        wait_neg(sA + 8112);
        chk("after_done_busy", int'(busy), 0);
        chk("after_done_mac_hold", int'(mac_hold), 1);
        cap_en = 1'b0;
        chk("runA_rd_count", cap_n, TAPS);
        for (int n = 0; n < 8; n++) begin
            chk("spot_map_addr", cap_map[spot_k[n]], spot_map[n]);
            chk("spot_k_addr", cap_kad[spot_k[n]], spot_kad[n]);
            chk("spot_out_idx", cap_oidx[spot_k[n]], spot_oidx[n]);
        end
        chk("spot_win_last_23", cap_wl[23], 0);
        chk("spot_win_last_24", cap_wl[24], 1);
        chk("spot_win_last_25", cap_wl[25], 0);

        // Run B: abort after 2000 RUN cycles
        @(negedge clk_in);
        start = 1'b1;
        sB = cyc_cnt + 1;
        push_run(sB, 2000, 1'b0);
        @(negedge clk_in);
        start = 1'b0;
        wait_neg(sB + 3 + 1999);
        abort = 1'b1;
        @(negedge clk_in);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_mac_hold", int'(mac_hold), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_map_addr", int'(map_addr), 0);

        // start and abort together in IDLE: abort wins
        @(negedge clk_in);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_busy", int'(busy), 0);
        repeat (3) @(negedge clk_in);
        chk("start_abort_idle_busy2", int'(busy), 0);

        // Run C: start held high, two back-to-back runs
        start = 1'b1;
        sC = cyc_cnt + 1;
        push_run(sC, TAPS, 1'b1);
        sC2 = sC + 8113;
        push_run(sC2, TAPS, 1'b1);
        wait_neg(sC + 8112);
        chk("between_runs_busy", int'(busy), 0);
        chk("between_runs_mac_hold", int'(mac_hold), 1);
        wait_neg(sC2 + 10);
        start = 1'b0;
        wait_neg(sC2 + 8113);
        chk("runC_end_busy", int'(busy), 0);

        // Run D: asynchronous reset between clock edges in the middle of RUN
        @(negedge clk_in);
        start = 1'b1;
        sD = cyc_cnt + 1;
        push_run(sD, 99, 1'b0);
        @(negedge clk_in);
        start = 1'b0;
        wait_neg(sD + 3 + 98);
        @(posedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_rd_en", int'(rd_en), 0);
        chk("async_rst_mac_hold", int'(mac_hold), 1);
        chk("async_rst_map_addr", int'(map_addr), 0);
        chk("async_rst_k_addr", int'(k_addr), 0);
        chk("async_rst_out_idx", int'(out_idx), 0);
        chk("async_rst_win_last", int'(win_last), 0);
        chk("async_rst_done", int'(done), 0);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_in);
        chk("post_rst_idle_busy", int'(busy), 0);
        chk("post_rst_idle_mac_hold", int'(mac_hold), 1);

        repeat (5) @(negedge clk_in);
        chk("tap_queue_empty", tap_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        chk("total_rd_en", n_rd, exp_rd);
        chk("total_done", n_done, exp_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_seq.md
Name: conv_window_seq

Overview:
- Sequencer for the 5x5 convolution MAC engine.
- Walks every 5x5 window of a 22x22 input feature map and issues one (map address, kernel address) pair per cycle to a synchronous map RAM and kernel ROM, whose outputs feed the MAC operands.
- Owns the MAC's hold input: releases it for a run and reasserts it at the end.
- Provides a start/busy/done handshake to the layer-level controller.

Parameters:
- MAP_W, 22, input map width = height
- K_W, 5, kernel width = height; taps per window = K_W*K_W = 25
- OUT_W, 18, output map width = height; must equal MAP_W-K_W+1
- MA_W, 9, map address width; must satisfy 2^MA_W >= MAP_W*MAP_W
- KA_W, 5, kernel address width; must satisfy 2^KA_W >= K_W*K_W
- WARM_CYC, 3, cycles between hold release and first address, covering the MAC's internal hold-delay pipeline
- DRAIN_CYC, 8, cycles after last address before done, covering RAM latency + multiplier + accumulate + saturate stages

Ports:
- clk_in, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, run request, sampled in IDLE only
- abort, in, 1, synchronous cancel
- busy, out, 1, high in any state other than IDLE
- done, out, 1, one-cycle pulse on normal completion
- mac_hold, out, 1, high = MAC held/cleared; low = MAC accumulating
- rd_en, out, 1, address pair valid this cycle
- map_addr, out, MA_W, map RAM read address
- k_addr, out, KA_W, kernel ROM read address
- win_last, out, 1, high with the 25th tap of each window
- out_idx, out, 9, output pixel index (r*OUT_W+c) of the current window

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all counters 0; outputs: busy=0, done=0, mac_hold=1, rd_en=0, map_addr=0, k_addr=0, win_last=0, out_idx=0. Reset mid-run abandons the run; no done is issued.
- All outputs are registered.
- States:
  - IDLE: mac_hold=1. If start=1, go to WARM; mac_hold=0 from the next cycle.
  - WARM: counts WARM_CYC cycles, then goes to RUN.
  - RUN: one address pair per cycle with rd_en=1, no gaps, for OUT_W*OUT_W*K_W*K_W = 8100 cycles, then goes to DRAIN.
  - DRAIN: rd_en=0, mac_hold=0 for DRAIN_CYC cycles, then goes to DONE.
  - DONE: one cycle; done=1, mac_hold=1; then goes to IDLE.
- Loop order:
  - Outer: window row r = 0..OUT_W-1, then window column c = 0..OUT_W-1.
  - Inner: tap row i = 0..K_W-1, then tap column j = 0..K_W-1.
- Address formulas:
  - map_addr = (r+i)*MAP_W + (c+j)
  - k_addr = i*K_W + j
  - Compute incrementally with adders only (row-base registers); no multipliers.
- win_last=1 when i=j=K_W-1; out_idx is held constant across the window's 25 taps.
- Counter wrap:
  - j wraps to 0 and increments i.
  - i wraps to 0 and increments c.
  - c wraps to 0 and increments r.
  - At r=c=i=j=max, the transition is RUN->DRAIN, not a wrap.
- start while busy=1: ignored, no queuing.
- start and abort both high in IDLE: abort wins; remain in IDLE.
- abort=1 in WARM/RUN/DRAIN/DONE: next cycle state=IDLE, mac_hold=1, rd_en=0, counters cleared, no done pulse.
- start held high continuously: a new run begins on the cycle after DONE (IDLE sees start), so there is exactly one IDLE cycle between runs with mac_hold=1. This cycle clears the MAC accumulator.
- done and rd_en are never high in the same cycle.

Test Plan:
- Reset release, then start at cycle 0:
  - busy=1 and mac_hold=0 at cycle 1.
  - First rd_en at cycle 4.
  - Last rd_en at cycle 8103.
  - done=1 only at cycle 8112, with mac_hold=1 at cycle 8112.
  - Exactly 8100 rd_en cycles in total.
- Address check for first window: map_addr 0,1,2,3,4,22,23,24,25,26,...,88..92; k_addr 0..24; win_last only on tap 25; out_idx=0. Second window: map_addr starts at 1, out_idx=1.
- Window (r=1,c=0): out_idx=18, first map_addr=22. Window (17,17): out_idx=323, first map_addr=391, last map_addr=483, k_addr=24.
- abort at cycle 2000 of RUN: next cycle busy=0, rd_en=0, mac_hold=1; no done. Subsequent start gives a full run from map_addr 0.
- start pulsed at cycle 500 during RUN: no effect; done timing unchanged. start held high: second run's first rd_en 5 cycles after the first done.
- rst_n low asynchronously mid-RUN (between clock edges): outputs go to reset values immediately, without waiting for a clock edge. After release, IDLE until start.
